fifo_param: RTL
===============

# fifo_param

Parametrised successor to the channel FIFO. It buffers `BUS_SIZE`-bit words, each with a one-bit valid tag, in a power-of-two deep circular buffer. It adds configurable almost-full/almost-empty thresholds, latched at reset, and hysteretic `pause`/`continua` flow control toward the upstream producer. It also provides an explicit fill count, plus sticky overflow and underflow error flags. It sits between a producer and a consumer in the routing fabric, one instance per channel.

## Interface

Parameters:

- `BUS_SIZE`, 6: data word width in bits.
- `ADDR_WIDTH`, 3: pointer width.
- `DEPTH`, `1 << ADDR_WIDTH`: entry count. Always a power of two; do not override.

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `valid`  in  1  tag stored alongside `data_in`.
- `data_in`  in  `BUS_SIZE`  write data.
- `umbral_alto`  in  `ADDR_WIDTH+1`  almost-full threshold, sampled during reset.
- `umbral_bajo`  in  `ADDR_WIDTH+1`  almost-empty threshold, sampled during reset.
- `data_out`  out  `BUS_SIZE`  registered read data.
- `valid_out`  out  1  registered tag of the last popped word.
- `fill`  out  `ADDR_WIDTH+1`  current occupancy, 0..`DEPTH`.
- `empty`  out  1  `fill == 0`.
- `full`  out  1  `fill == DEPTH`.
- `almost_full`  out  1  `fill >= umbral_alto` (latched value).
- `almost_empty`  out  1  `fill <= umbral_bajo` (latched value).
- `pause`  out  1  hysteretic stop request to the producer.
- `continua`  out  1  `~pause`.
- `err_overflow`  out  1  sticky; set by a rejected push.
- `err_underflow`  out  1  sticky; set by a rejected pop.

## Operation

- Storage: `DEPTH` x (`BUS_SIZE`+1) array plus `wr_ptr`, `rd_ptr` (`ADDR_WIDTH` bits) and a `fill` register (`ADDR_WIDTH+1` bits).
  - Pointers wrap naturally from `DEPTH-1` to 0.
  - `fill` is a counter, not derived from the pointers, so the full and empty states are distinguishable.
- Push is accepted when `push && (!full || pop_acc)`. On acceptance, `{valid, data_in}` is written at `wr_ptr` and `wr_ptr` increments.
- Pop is accepted when `pop && !empty`. On acceptance:
  - `{valid_out, data_out}` load the entry at `rd_ptr`.
  - `rd_ptr` increments.
  - The vacated entry is not cleared.
- `fill` update:
  - +1 on a push-only acceptance.
  - −1 on a pop-only acceptance.
  - Unchanged when both are accepted or neither is.
- Push and pop in the same cycle:
  - When `full`: both are accepted and `fill` stays at `DEPTH`.
  - When `empty`: the push is accepted, the pop is rejected (no bypass), `fill` becomes 1 and `err_underflow` sets.
- A push while `full` without an accepted pop is dropped: memory and pointers are unchanged and `err_overflow` is set.
- A pop while `empty` is ignored: `data_out`/`valid_out` hold and `err_underflow` is set.
- Error flags are sticky until `reset`.
- Thresholds: `umbral_alto`/`umbral_bajo` are captured into internal registers on every cycle with `reset`=1 and held otherwise.
  - Reset capture is mandatory, and the thresholds must be stable during reset.
  - `umbral_bajo < umbral_alto` is required; other values give undefined flow control but must still leave the storage correct.
- Pause state machine, with two states RUN (`pause`=0) and STOP (`pause`=1):
  - RUN → STOP when the registered `fill >= alto`.
  - STOP → RUN when the registered `fill <= bajo`.
  - Otherwise the state holds.

## Timing

- Reset values:
  - Pointers and `fill` = 0.
  - `data_out` = 0, `valid_out` = 0.
  - Pause state = RUN, so `pause`=0 and `continua`=1.
  - Both error flags = 0.
  - Storage contents are don't-care.
- Combinational flags: `empty`, `full`, `almost_full` and `almost_empty` decode from the `fill` register. They change in the same cycle `fill` updates, i.e. one edge after the accepted push/pop.
- Read latency: `data_out`/`valid_out` are valid one clock after the edge at which `pop` is sampled and accepted.
- Pause latency: `pause` is evaluated from the post-edge `fill`, so it lags `fill` by one further clock (two edges after the causing push/pop).
  - With `DEPTH − umbral_alto >= 2`, a producer that reacts to `pause` one cycle late still cannot overflow.
- Reset in mid-operation: reset takes effect at the next edge. All stored words are discarded and the thresholds are re-captured; a push/pop sampled in the reset cycle is ignored.

## Test plan

Settings for all scenarios: `DEPTH`=8, `umbral_alto`=6, `umbral_bajo`=2.

- **Fill and drain:** 8 pushes of 0x01..0x08 (`valid`=1), then 8 pops. Required:
  - `full`=1 after the 8th push.
  - `data_out` sequence 0x01..0x08, each one clock after its pop.
  - `empty`=1 at the end; no error flags.
- **Hysteresis:** push to `fill`=6; `pause` rises one clock after `fill`=6. Pop to `fill`=3; `pause` stays 1. Pop to `fill`=2; `pause` falls one clock later and `continua`=1.
- **Overflow:** with `full`, push 0x3F for one cycle alone. Required: `fill` stays 8, `err_overflow`=1 permanently, and a full drain shows 0x3F was never stored.
- **Simultaneous full:** with `full`, assert `push`+`pop`. Required: `fill` stays 8, the oldest word is read out, the new word appears last in the drain, and no error.
- **Underflow/empty collision:** with `empty`, assert `push`(0x15)+`pop`. Required:
  - `fill`=1, `err_underflow`=1, `data_out` unchanged.
  - The next pop returns 0x15.
- **Wrap and tag:** run 20 push/pop cycles with alternating `valid`. Required: `valid_out` matches each word's tag across the pointer wrap. Then assert `reset` mid-stream: all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised tagged FIFO with fill count, thresholds, hysteretic pause and sticky errors
module fifo_param #(
    parameter int BUS_SIZE   = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  valid,
    input  logic [BUS_SIZE-1:0]   data_in,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [BUS_SIZE-1:0]   data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   fill,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  pause,
    output logic                  continua,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

    logic [BUS_SIZE:0]     mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic [BUS_SIZE-1:0]   data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic [ADDR_WIDTH:0]   alto_q, alto_d;
    logic [ADDR_WIDTH:0]   bajo_q, bajo_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unf_q, err_unf_d;
    state_t                state_q, state_d;
    logic                  push_acc, pop_acc;

    assign empty        = (fill_q == '0);
    assign full         = (fill_q == FULL_CNT);
    assign almost_full  = (fill_q >= alto_q);
    assign almost_empty = (fill_q <= bajo_q);

    always_comb begin
        pop_acc     = pop && !empty;
        // a full FIFO still takes a write when the same cycle frees a slot
        push_acc    = push && (!full || pop_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d                  = rd_ptr_q + PTR_ONE;
            {valid_out_d, data_out_d} = mem_q[rd_ptr_q];
        end
        case ({push_acc, pop_acc})
            2'b10:   fill_d = fill_q + CNT_ONE;
            2'b01:   fill_d = fill_q - CNT_ONE;
            default: fill_d = fill_q;
        endcase
        err_ovf_d = err_ovf_q | (push && !push_acc);
        err_unf_d = err_unf_q | (pop && empty);
        alto_d    = reset ? umbral_alto : alto_q;
        bajo_d    = reset ? umbral_bajo : bajo_q;
        // hysteresis works from the registered fill, so pause lags fill by one edge
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (fill_q >= alto_q) state_d = ST_STOP;
            ST_STOP: if (fill_q <= bajo_q) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        alto_q <= alto_d;
        bajo_q <= bajo_d;
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            state_q     <= ST_RUN;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            state_q     <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem_q[wr_ptr_q] <= {valid, data_in};
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign fill          = fill_q;
    assign pause         = (state_q == ST_STOP);
    assign continua      = (state_q != ST_STOP);
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule
